opentdc_event_fifo: RTL and testbench

Timestamp event buffer between the TDC delay-line capture logic and the Wishbone slave register file of the OpenTDC core. Each detected edge delivers a fine code; the block tags it with the free-running coarse time, stores the pair in a show-ahead FIFO, and the Wishbone decoder pops entries one word at a time. Loss of events when software reads too slowly is reported through a sticky overflow flag and a saturating lost-event counter.

---
 rtl/opentdc_event_fifo_if.sv | 32 +++
 rtl/opentdc_event_fifo.sv | 104 ++++++++++
 tb/tb_opentdc_event_fifo.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/opentdc_event_fifo_if.sv
// Capture/readout bundle between the TDC front end, the event FIFO and the Wishbone decoder.
// The producer and consumer side (master) drive the strobes; the FIFO (slave) returns the head entry and status.
interface opentdc_event_fifo_if #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned FINE_W   = 8,
  parameter int unsigned COARSE_W = 24
);
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned DATA_W = FINE_W + COARSE_W;

  logic                en_i;
  logic [COARSE_W-1:0] coarse_i;
  logic                evt_i;
  logic [FINE_W-1:0]   fine_i;
  logic                rd_i;
  logic                clr_i;
  logic [DATA_W-1:0]   data_o;
  logic                valid_o;
  logic [CNT_W-1:0]    count_o;
  logic                overflow_o;
  logic [7:0]          lost_o;

  modport master (
    output en_i, coarse_i, evt_i, fine_i, rd_i, clr_i,
    input  data_o, valid_o, count_o, overflow_o, lost_o
  );

  modport slave (
    input  en_i, coarse_i, evt_i, fine_i, rd_i, clr_i,
    output data_o, valid_o, count_o, overflow_o, lost_o
  );
endinterface

// File: rtl/opentdc_event_fifo.sv
// Show-ahead timestamp FIFO: tags each fine code with the coarse time, buffers it for Wishbone
// readout, and counts events dropped while full.
module opentdc_event_fifo #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned FINE_W   = 8,
  parameter int unsigned COARSE_W = 24
) (
  input logic                 clk_i,
  input logic                 rst_n_i,
  opentdc_event_fifo_if.slave bus
);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned DATA_W = FINE_W + COARSE_W;
  localparam int unsigned LOST_W = 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic [LOST_W-1:0] lost_q, lost_d;

  logic              full;
  logic              attempt;
  logic              push;
  logic              pop;
  logic              drop;
  logic [DATA_W-1:0] entry;

  // Next-state: clear overrides push/pop; the head register is refilled from the new read pointer.
  always_comb begin
    entry    = {bus.coarse_i, bus.fine_i};
    full     = (count_q == CNT_W'(DEPTH));
    attempt  = bus.evt_i & bus.en_i;
    pop      = bus.rd_i & valid_q;
    push     = attempt & (~full | bus.rd_i);
    drop     = attempt & full & ~bus.rd_i;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = data_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    lost_d   = lost_q;

    if (bus.clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      data_d   = '0;
      valid_d  = 1'b0;
      ovf_d    = 1'b0;
      lost_d   = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      valid_d  = (count_d != '0);
      if (drop) begin
        ovf_d = 1'b1;
        if (lost_q != '1) lost_d = lost_q + LOST_W'(1);
      end
      // A single remaining entry that is being written this cycle is not in memory yet.
      if (count_d == '0)                          data_d = '0;
      else if (push && (count_d == CNT_W'(1)))    data_d = entry;
      else                                        data_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      lost_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      lost_q   <= lost_d;
    end
  end

  // Storage carries no reset; only occupied slots are ever presented.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && !bus.clr_i && push) mem_q[wr_ptr_q] <= entry;
  end

  assign bus.data_o     = data_q;
  assign bus.valid_o    = valid_q;
  assign bus.count_o    = count_q;
  assign bus.overflow_o = ovf_q;
  assign bus.lost_o     = lost_q;
endmodule

// File: tb/tb_opentdc_event_fifo.sv
// Directed bench for opentdc_event_fifo: queue-based reference model checked every cycle,
// plus hand-computed literal expectations at key points.
module tb_opentdc_event_fifo;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned FINE_W   = 8;
  localparam int unsigned COARSE_W = 24;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  opentdc_event_fifo_if #(.DEPTH(DEPTH), .FINE_W(FINE_W), .COARSE_W(COARSE_W)) bus ();

  opentdc_event_fifo #(.DEPTH(DEPTH), .FINE_W(FINE_W), .COARSE_W(COARSE_W)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );

  logic [31:0] m_q[$];
  bit          m_ovf;
  int          m_lost;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the buffer must hold after the coming edge.
  task automatic model_step();
    if (!rst_n || bus.clr_i) begin
      m_q.delete();
      m_ovf  = 1'b0;
      m_lost = 0;
    end else begin
      bit attempt, do_pop, do_push;
      attempt = bus.evt_i && bus.en_i;
      do_pop  = bus.rd_i && (m_q.size() > 0);
      do_push = attempt && ((m_q.size() < int'(DEPTH)) || bus.rd_i);
      if (attempt && !do_push) begin
        m_ovf = 1'b1;
        if (m_lost < 255) m_lost++;
      end
      if (do_pop) void'(m_q.pop_front());
      if (do_push) m_q.push_back({bus.coarse_i, bus.fine_i});
    end
  endtask

  task automatic check_model();
    logic [31:0] exp_data;
    exp_data = (m_q.size() > 0) ? m_q[0] : 32'h0;
    chk("model_data",  bus.data_o, exp_data);
    chk("model_valid", 32'(bus.valid_o), 32'(m_q.size() != 0));
    chk("model_count", 32'(bus.count_o), 32'(m_q.size()));
    chk("model_ovf",   32'(bus.overflow_o), 32'(m_ovf));
    chk("model_lost",  32'(bus.lost_o), 32'(m_lost));
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic push(input logic [7:0] f);
    bus.evt_i  = 1'b1;
    bus.fine_i = f;
    cycle();
    bus.evt_i  = 1'b0;
  endtask

  task automatic pop();
    bus.rd_i = 1'b1;
    cycle();
    bus.rd_i = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"},  bus.data_o, 32'h0);
    chk({tag, "_valid"}, 32'(bus.valid_o), 32'h0);
    chk({tag, "_count"}, 32'(bus.count_o), 32'h0);
    chk({tag, "_ovf"},   32'(bus.overflow_o), 32'h0);
    chk({tag, "_lost"},  32'(bus.lost_o), 32'h0);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.en_i     = 1'b0;
    bus.coarse_i = '0;
    bus.evt_i    = 1'b0;
    bus.fine_i   = '0;
    bus.rd_i     = 1'b0;
    bus.clr_i    = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    chk_zero("reset");

    // Basic push
    bus.en_i     = 1'b1;
    bus.coarse_i = 24'h000123;
    push(8'h5A);
    chk("basic_valid", 32'(bus.valid_o), 32'h1);
    chk("basic_count", 32'(bus.count_o), 32'h1);
    chk("basic_data",  bus.data_o, 32'h0001235A);
    pop();
    chk("basic_pop_valid", 32'(bus.valid_o), 32'h0);

    // Ordering
    for (int i = 1; i <= 8; i++) begin
      bus.coarse_i = 24'(32'h100 + i * 3);
      push(8'(i));
    end
    chk("order_count", 32'(bus.count_o), 32'd8);
    for (int i = 1; i <= 8; i++) begin
      chk("order_head", 32'(bus.data_o[7:0]), 32'(i));
      pop();
    end
    chk("order_empty_valid", 32'(bus.valid_o), 32'h0);
    chk("order_empty_data",  bus.data_o, 32'h0);

    // Overflow
    for (int i = 0; i < 8; i++) begin
      bus.coarse_i = 24'(32'h200 + i);
      push(8'(32'h10 + i));
    end
    bus.evt_i = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus.fine_i = 8'(i);
      cycle();
    end
    bus.evt_i = 1'b0;
    chk("ovf_flag",  32'(bus.overflow_o), 32'h1);
    chk("ovf_lost",  32'(bus.lost_o), 32'd255);
    chk("ovf_count", 32'(bus.count_o), 32'd8);
    chk("ovf_head",  bus.data_o, 32'h00020010);
    bus.clr_i = 1'b1;
    bus.evt_i = 1'b1;
    bus.rd_i  = 1'b1;
    cycle();
    bus.clr_i = 1'b0;
    bus.evt_i = 1'b0;
    bus.rd_i  = 1'b0;
    chk_zero("clr");

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) begin
      bus.coarse_i = 24'(32'h300 + i);
      push(8'(32'h20 + i));
    end
    bus.evt_i = 1'b1;
    bus.rd_i  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.coarse_i = 24'(32'h400 + i);
      bus.fine_i   = 8'(32'h30 + i);
      cycle();
    end
    bus.evt_i = 1'b0;
    bus.rd_i  = 1'b0;
    chk("fullrw_count", 32'(bus.count_o), 32'd8);
    chk("fullrw_ovf",   32'(bus.overflow_o), 32'h0);
    chk("fullrw_head",  bus.data_o, 32'h00030525);
    for (int i = 0; i < 8; i++) pop();

    // Empty FIFO with simultaneous push and pop
    bus.coarse_i = 24'h000777;
    bus.evt_i = 1'b1;
    bus.rd_i  = 1'b1;
    bus.fine_i = 8'h99;
    cycle();
    bus.evt_i = 1'b0;
    bus.rd_i  = 1'b0;
    chk("emptyrw_count", 32'(bus.count_o), 32'h1);
    chk("emptyrw_data",  bus.data_o, 32'h00077799);
    pop();

    // Wrap-around
    for (int i = 0; i < 20; i++) begin
      bus.coarse_i = 24'(32'h500 + i * 7);
      push(8'(32'h40 + i));
      pop();
    end
    bus.en_i  = 1'b0;
    bus.evt_i = 1'b1;
    cycle();
    bus.evt_i = 1'b0;
    bus.en_i  = 1'b1;
    chk("disabled_count", 32'(bus.count_o), 32'h0);
    bus.coarse_i = 24'hFFFFFF;
    push(8'hAA);
    bus.coarse_i = 24'h000000;
    push(8'hBB);
    chk("coarse_max", bus.data_o, 32'hFFFFFFAA);
    pop();
    chk("coarse_zero", bus.data_o, 32'h000000BB);
    pop();

    // Reset mid-operation
    for (int i = 0; i < 5; i++) begin
      bus.coarse_i = 24'(32'h600 + i);
      push(8'(32'h60 + i));
    end
    rst_n     = 1'b0;
    bus.evt_i = 1'b1;
    bus.rd_i  = 1'b1;
    cycle();
    rst_n     = 1'b1;
    bus.evt_i = 1'b0;
    bus.rd_i  = 1'b0;
    chk_zero("midrst");
    bus.coarse_i = 24'h000ABC;
    push(8'h01);
    chk("midrst_push_count", 32'(bus.count_o), 32'h1);
    chk("midrst_push_data",  bus.data_o, 32'h000ABC01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
